// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, circular return-address stack
// and the IF/ID pipeline register.
module fetch_unit #(
  parameter int unsigned    PC_W      = 12,
  parameter int unsigned    INST_W    = 19,
  parameter int unsigned    OFF_W     = 8,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [1:0]                   pc_sel_i,
  input  logic [OFF_W-1:0]             branch_off_i,
  input  logic [PC_W-1:0]              jump_target_i,
  input  logic                         push_call_i,
  input  logic                         err_clr_i,
  output logic [PC_W-1:0]              imem_addr_o,
  input  logic [INST_W-1:0]            imem_rdata_i,
  output logic [INST_W-1:0]            if_id_inst_o,
  output logic [PC_W-1:0]              if_id_pc_o,
  output logic                         if_id_valid_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_overflow_o,
  output logic                         ras_underflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  logic [PtrW-1:0]   wp_q, wp_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   if_pc_q;
  logic              valid_q;

  logic              ras_we;
  logic [PtrW-1:0]   ras_widx;
  logic [PC_W-1:0]   ras_wdata;
  logic [PtrW-1:0]   top_idx;
  logic [PC_W-1:0]   pc_seq;
  logic              empty, full, pop, ovf_set, unf_set;

  // wp_q points at the next free slot; when full it also points at the oldest entry.
  assign top_idx   = wp_q - PtrW'(1);
  assign pc_seq    = pc_q + PC_W'(1);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CntW'(RAS_DEPTH));
  assign ras_wdata = if_pc_q + PC_W'(1);

  always_comb begin
    pc_d     = pc_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = wp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    pop      = 1'b0;
    if (!stall_i) begin
      unique case (pc_sel_i)
        2'b00: pc_d = pc_seq;
        2'b01: pc_d = pc_q + PC_W'($signed(branch_off_i));
        2'b10: pc_d = jump_target_i;
        2'b11: begin
          if (empty) begin
            pc_d    = pc_seq;
            unf_set = 1'b1;
          end else begin
            pc_d = ras_q[top_idx];
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_seq;
      endcase
      // A push coinciding with a pop replaces the top entry in place.
      if (push_call_i && pop) begin
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else if (push_call_i) begin
        ras_we = 1'b1;
        wp_d   = wp_q + PtrW'(1);
        if (full) ovf_set = 1'b1;
        else      cnt_d   = cnt_q + CntW'(1);
      end else if (pop) begin
        wp_d  = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end
    end
    ovf_d = ovf_set | (ovf_q & ~err_clr_i);
    unf_d = unf_set | (unf_q & ~err_clr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (ras_we) ras_q[ras_widx] <= ras_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q  <= '0;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      inst_q  <= imem_rdata_i;
      if_pc_q <= pc_q;
      valid_q <= 1'b1;
    end
  end

  assign imem_addr_o     = pc_q;
  assign if_id_inst_o    = inst_q;
  assign if_id_pc_o      = if_pc_q;
  assign if_id_valid_o   = valid_q;
  assign ras_count_o     = cnt_q;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = unf_q;

endmodule
